// File: rtl/baby_kyber_pkg.sv
// Shared constants, types and helpers for the baby-Kyber decryption datapath.
// Coefficients arrive as signed 32-bit values and are reduced to 0..Q-1 on capture.
package baby_kyber_pkg;

  localparam int Q     = 17;
  localparam int N     = 4;
  localparam int K     = 2;
  localparam int QHALF = 9;

  typedef logic signed [31:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // SV '%' truncates toward zero, so negative remainders need one fold back up.
  function automatic coeff_t mod_q_norm(input coeff_t x, input int q);
    coeff_t r;
    r = x % q;
    if (r < 0) begin
      r = r + q;
    end
    return r;
  endfunction

endpackage

// File: rtl/kyber_mac_unit.sv
// Serial negacyclic multiply-accumulate: one sk*u product per cycle into an N-lane
// accumulator bank, walking (k,i,j) so that acc = sum_k sk[k]*u[k] mod (x^N+1).
module kyber_mac_unit
  import baby_kyber_pkg::*;
#(
  parameter int Q  = baby_kyber_pkg::Q,
  parameter int N  = baby_kyber_pkg::N,
  parameter int K  = baby_kyber_pkg::K,
  parameter int AW = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        en,
  input  logic [$clog2(Q)-1:0]        sk_norm [K][N],
  input  logic [$clog2(Q)-1:0]        u_norm  [K][N],
  output logic                        last,
  output logic signed [AW-1:0]        acc     [N]
);

  localparam int CW = $clog2(Q);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N - 1);
  localparam logic [NW:0]   N_EXT  = (NW + 1)'(N);

  logic [KW-1:0]         k_reg;
  logic [NW-1:0]         i_reg;
  logic [NW-1:0]         j_reg;
  logic [CW-1:0]         a_op;
  logic [CW-1:0]         b_op;
  logic [2*CW-1:0]       prod;
  logic signed [AW-1:0]  term;
  logic [NW:0]           deg;
  logic                  wrap;
  logic [NW-1:0]         idx;
  logic signed [AW-1:0]  acc_reg  [N];
  logic signed [AW-1:0]  acc_next [N];

  assign a_op = sk_norm[k_reg][i_reg];
  assign b_op = u_norm[k_reg][j_reg];
  assign prod = {{CW{1'b0}}, a_op} * {{CW{1'b0}}, b_op};
  assign term = $signed({{(AW - 2*CW){1'b0}}, prod});

  // x^(i+j) with i+j >= N folds to -x^(i+j-N) in Z_Q[x]/(x^N+1).
  assign deg  = {1'b0, i_reg} + {1'b0, j_reg};
  assign wrap = (deg >= N_EXT);
  assign idx  = wrap ? NW'(deg - N_EXT) : NW'(deg);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign acc_next[gi] = clear ? '0 :
                            (en && (idx == NW'(gi))) ?
                              (wrap ? (acc_reg[gi] - term) : (acc_reg[gi] + term)) :
                              acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg <= '0;
      i_reg <= '0;
      j_reg <= '0;
      for (int a = 0; a < N; a++) begin
        acc_reg[a] <= '0;
      end
    end else begin
      acc_reg <= acc_next;
      if (clear) begin
        k_reg <= '0;
        i_reg <= '0;
        j_reg <= '0;
      end else if (en) begin
        if (j_reg == N_LAST) begin
          j_reg <= '0;
          if (i_reg == N_LAST) begin
            i_reg <= '0;
            k_reg <= (k_reg == K_LAST) ? '0 : (k_reg + 1'b1);
          end else begin
            i_reg <= i_reg + 1'b1;
          end
        end else begin
          j_reg <= j_reg + 1'b1;
        end
      end
    end
  end

  assign last = en && (k_reg == K_LAST) && (i_reg == N_LAST) && (j_reg == N_LAST);
  assign acc  = acc_reg;

endmodule

// File: rtl/baby_kyber_decrypt.sv
// Baby-Kyber decryption: capture (u, v, sk), accumulate sk.u serially, then decode
// each coefficient of v - sk.u to one message bit and hold it until consumed.
module baby_kyber_decrypt
  import baby_kyber_pkg::*;
#(
  parameter int Q = baby_kyber_pkg::Q,
  parameter int N = baby_kyber_pkg::N,
  parameter int K = baby_kyber_pkg::K
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  coeff_t        u  [K][N],
  input  coeff_t        v  [N],
  input  coeff_t        sk [K][N],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  message
);

  localparam int CW = $clog2(Q);
  localparam int AW = 16;

  state_t                state_reg;
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic [N-1:0]          message_reg;

  logic [CW-1:0]         u_norm  [K][N];
  logic [CW-1:0]         sk_norm [K][N];
  logic [CW-1:0]         v_norm  [N];
  logic [CW-1:0]         u_reg   [K][N];
  logic [CW-1:0]         sk_reg  [K][N];
  logic [CW-1:0]         v_reg   [N];

  logic                  accept;
  logic                  mac_en;
  logic                  mac_last;
  logic signed [AW-1:0]  acc [N];
  logic [N-1:0]          dec_bits;

  assign accept = (state_reg == IDLE) && in_valid;
  assign mac_en = (state_reg == MAC);

  genvar gi, gk;
  generate
    for (gk = 0; gk < K; gk++) begin : g_rank
      for (gi = 0; gi < N; gi++) begin : g_coef
        assign u_norm[gk][gi]  = CW'(mod_q_norm(u[gk][gi], Q));
        assign sk_norm[gk][gi] = CW'(mod_q_norm(sk[gk][gi], Q));
      end
    end
    for (gi = 0; gi < N; gi++) begin : g_vnorm
      assign v_norm[gi] = CW'(mod_q_norm(v[gi], Q));
    end
  endgenerate

  kyber_mac_unit #(
    .Q  (Q),
    .N  (N),
    .K  (K),
    .AW (AW)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .en      (mac_en),
    .sk_norm (sk_reg),
    .u_norm  (u_reg),
    .last    (mac_last),
    .acc     (acc)
  );

  // round(2w/Q) mod 2 == 1 exactly when 2Q <= 4w+Q < 4Q, i.e. w sits nearer Q/2 than 0.
  generate
    for (gi = 0; gi < N; gi++) begin : g_decode
      coeff_t w;
      assign w = mod_q_norm(coeff_t'(v_reg[gi]) - coeff_t'(acc[gi]), Q);
      assign dec_bits[N-1-gi] = ((4*w + Q) >= 2*Q) && ((4*w + Q) < 4*Q);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      message_reg   <= '0;
      for (int a = 0; a < K; a++) begin
        for (int b = 0; b < N; b++) begin
          u_reg[a][b]  <= '0;
          sk_reg[a][b] <= '0;
        end
      end
      for (int b = 0; b < N; b++) begin
        v_reg[b] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            u_reg        <= u_norm;
            sk_reg       <= sk_norm;
            v_reg        <= v_norm;
            in_ready_reg <= 1'b0;
            state_reg    <= MAC;
          end
        end
        MAC: begin
          if (mac_last) begin
            state_reg <= REDUCE;
          end
        end
        REDUCE: begin
          message_reg   <= dec_bits;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign message   = message_reg;

endmodule

// File: tb/tb_baby_kyber_decrypt.sv
// Scoreboard bench: stimulus pushes expected messages at accept, a negedge monitor
// pops and compares on each output handshake, plus hold/latency/reset checks.
module tb_baby_kyber_decrypt;
  import baby_kyber_pkg::*;

  localparam int TQ = 17;
  localparam int TN = 4;
  localparam int TK = 2;
  // Accept edge -> 32 MAC edges -> 1 REDUCE edge: out_valid is high in cycle 34,
  // counting the first MAC cycle as cycle 1, i.e. 33 edges after the accept edge.
  localparam int LAT_EDGES = 33;

  typedef longint poly_t [TN];
  typedef coeff_t cvec_t [TK][TN];
  typedef coeff_t cpoly_t [TN];

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_valid;
  logic [TN-1:0] message;
  coeff_t        u  [TK][TN];
  coeff_t        v  [TN];
  coeff_t        sk [TK][TN];

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            acc_cyc  = 0;
  int            txn      = 0;
  logic [TN-1:0] exp_q [$];
  logic [TN-1:0] exp_next = '0;
  logic [TN-1:0] mon_exp;
  logic          prev_valid = 1'b0;
  logic          prev_hold  = 1'b0;
  logic [TN-1:0] prev_msg   = '0;

  cvec_t         ts, tu;
  cpoly_t        tv;
  poly_t         a_mat [TK][TK];
  poly_t         s_p [TK], e_p [TK], t_p [TK], r_p [TK], e1_p [TK], u_p [TK];
  poly_t         e2_p, v_p, tmp;

  baby_kyber_decrypt #(.Q(TQ), .N(TN), .K(TK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .v         (v),
    .sk        (sk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .message   (message)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic longint nq(input longint x);
    longint r;
    r = x % TQ;
    if (r < 0) r = r + TQ;
    return r;
  endfunction

  // Schoolbook product then fold with x^N = -1.
  function automatic poly_t pmul(input poly_t a, input poly_t b);
    longint full [2*TN-1];
    poly_t  c;
    for (int d = 0; d < 2*TN-1; d++) full[d] = 0;
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++)
        full[i+j] += a[i] * b[j];
    for (int d = 0; d < TN; d++) begin
      if (d + TN < 2*TN-1) c[d] = nq(full[d] - full[d+TN]);
      else                 c[d] = nq(full[d]);
    end
    return c;
  endfunction

  // Message bit i is 1 when v - <sk,u> at coefficient i lies in 5..12 (near Q/2).
  function automatic logic [TN-1:0] ref_decrypt(input cvec_t s, input cvec_t uu, input cpoly_t vv);
    poly_t         dot, a, b, p;
    longint        w;
    logic [TN-1:0] m;
    for (int d = 0; d < TN; d++) dot[d] = 0;
    for (int k = 0; k < TK; k++) begin
      for (int d = 0; d < TN; d++) begin
        a[d] = nq(longint'(s[k][d]));
        b[d] = nq(longint'(uu[k][d]));
      end
      p = pmul(a, b);
      for (int d = 0; d < TN; d++) dot[d] += p[d];
    end
    for (int i = 0; i < TN; i++) begin
      w = nq(longint'(vv[i]) - dot[i]);
      m[TN-1-i] = (w >= 5) && (w <= 12);
    end
    return m;
  endfunction

  function automatic coeff_t rnd_coef(input bit wide);
    if (wide) return coeff_t'($urandom());
    return coeff_t'($urandom_range(40)) - 20;
  endfunction

  function automatic longint tern();
    return longint'($urandom_range(2)) - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    for (int k = 0; k < TK; k++)
      for (int d = 0; d < TN; d++) begin
        u[k][d]  = rnd_coef(1'b1);
        sk[k][d] = rnd_coef(1'b1);
      end
    for (int d = 0; d < TN; d++) v[d] = rnd_coef(1'b1);
  endtask

  task automatic send(input cvec_t s, input cvec_t uu, input cpoly_t vv, input logic [TN-1:0] e);
    int t;
    t        = 0;
    exp_next = e;
    sk       = s;
    u        = uu;
    v        = vv;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || !in_ready) && t < 300) begin
      tick();
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic clear_vectors();
    for (int k = 0; k < TK; k++)
      for (int d = 0; d < TN; d++) begin
        ts[k][d] = 0;
        tu[k][d] = 0;
      end
    for (int d = 0; d < TN; d++) tv[d] = 0;
  endtask

  task automatic random_vectors(input bit wide);
    for (int k = 0; k < TK; k++)
      for (int d = 0; d < TN; d++) begin
        ts[k][d] = rnd_coef(wide);
        tu[k][d] = rnd_coef(wide);
      end
    for (int d = 0; d < TN; d++) tv[d] = rnd_coef(wide);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(exp_next);
      acc_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hold  = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) begin
          check("out_valid_expected", exp_q.size() > 0, 1);
          check("latency", cyc - acc_cyc, LAT_EDGES);
        end
        if (prev_hold) check("hold_message", message, prev_msg);
        check("in_ready_in_done", in_ready, 0);
        if (out_ready && exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          txn++;
          $display("txn %0d message=%b expected=%b", txn, message, mon_exp);
          check("message", message, mon_exp);
        end
      end else if (prev_hold) begin
        check("hold_out_valid", out_valid, 1);
      end
      prev_hold  = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_msg   = message;
    end
  end

  initial begin
    logic [TN-1:0] m;
    int            t;
    bit            ok;

    clear_vectors();
    sk = ts;
    u  = tu;
    v  = tv;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_message", message, 0);
    rst_n = 1'b1;
    tick();

    // Zero key: w = v.
    clear_vectors();
    for (int k = 0; k < TK; k++)
      for (int d = 0; d < TN; d++) tu[k][d] = rnd_coef(1'b1);
    tv = '{9, 0, 9, 0};
    send(ts, tu, tv, 4'b1010);

    // Negacyclic wrap: x^1 * x^3 = -1.
    clear_vectors();
    ts[0][1] = 1;
    tu[0][3] = 1;
    tv = '{8, 0, 0, 0};
    send(ts, tu, tv, 4'b1000);

    clear_vectors();
    tv = '{4, 5, 12, 13};
    send(ts, tu, tv, 4'b0110);
    tv = '{-8, 0, 0, 0};
    send(ts, tu, tv, 4'b1000);
    tv = '{26, -34, -5, 30};
    send(ts, tu, tv, 4'b1010);
    wait_drain();

    for (int n = 0; n < 20; n++) begin
      random_vectors(n[0]);
      send(ts, tu, tv, ref_decrypt(ts, tu, tv));
    end
    wait_drain();

    // Backpressure: hold DONE for 10 cycles while offering new input.
    out_ready = 1'b0;
    random_vectors(1'b0);
    send(ts, tu, tv, ref_decrypt(ts, tu, tv));
    t = 0;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    exp_next = '0;
    in_valid = 1'b1;
    repeat (10) tick();
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of MAC abandons the operation.
    random_vectors(1'b1);
    send(ts, tu, tv, ref_decrypt(ts, tu, tv));
    repeat (15) tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    repeat (50) tick();
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_out_valid", out_valid, 0);
    clear_vectors();
    tv = '{9, 0, 9, 0};
    send(ts, tu, tv, 4'b1010);
    wait_drain();

    // Round trip through an encrypt model with a ternary key pair and noise.
    for (int i = 0; i < TK; i++) begin
      for (int j = 0; j < TK; j++)
        for (int d = 0; d < TN; d++) a_mat[i][j][d] = longint'($urandom_range(TQ - 1));
      for (int d = 0; d < TN; d++) begin
        s_p[i][d] = tern();
        e_p[i][d] = tern();
      end
    end
    for (int i = 0; i < TK; i++) begin
      for (int d = 0; d < TN; d++) t_p[i][d] = e_p[i][d];
      for (int j = 0; j < TK; j++) begin
        tmp = pmul(a_mat[i][j], s_p[j]);
        for (int d = 0; d < TN; d++) t_p[i][d] += tmp[d];
      end
    end
    for (int k = 0; k < TK; k++)
      for (int d = 0; d < TN; d++) ts[k][d] = coeff_t'(s_p[k][d]);

    for (int n = 0; n < 100; n++) begin
      m  = TN'($urandom_range(15));
      ok = 1'b0;
      for (int tries = 0; tries < 50 && !ok; tries++) begin
        for (int i = 0; i < TK; i++)
          for (int d = 0; d < TN; d++) begin
            r_p[i][d]  = tern();
            e1_p[i][d] = tern();
          end
        for (int d = 0; d < TN; d++) begin
          e2_p[d] = tern();
          v_p[d]  = e2_p[d] + (m[TN-1-d] ? QHALF : 0);
        end
        for (int j = 0; j < TK; j++) begin
          for (int d = 0; d < TN; d++) u_p[j][d] = e1_p[j][d];
          for (int i = 0; i < TK; i++) begin
            tmp = pmul(a_mat[i][j], r_p[i]);
            for (int d = 0; d < TN; d++) u_p[j][d] += tmp[d];
          end
        end
        for (int i = 0; i < TK; i++) begin
          tmp = pmul(t_p[i], r_p[i]);
          for (int d = 0; d < TN; d++) v_p[d] += tmp[d];
        end
        for (int k = 0; k < TK; k++)
          for (int d = 0; d < TN; d++) tu[k][d] = coeff_t'(u_p[k][d]);
        for (int d = 0; d < TN; d++) tv[d] = coeff_t'(v_p[d]);
        ok = (ref_decrypt(ts, tu, tv) == m);
      end
      send(ts, tu, tv, m);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baby_kyber_decrypt.md
BABY_KYBER_DECRYPT -- requirements
Module: baby_kyber_decrypt

Interface
REQ-001 The block SHALL have parameter Q, default 17: coefficient modulus.
REQ-002 The block SHALL have parameter N, default 4: polynomial length, ring Z_Q[x]/(x^N+1).
REQ-003 The block SHALL have parameter K, default 2: module rank.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: ciphertext and key present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept.
REQ-008 The block SHALL have port u, input, signed 32 x [K][N]: ciphertext vector from the encrypt stage.
REQ-009 The block SHALL have port v, input, signed 32 x [N]: ciphertext polynomial.
REQ-010 The block SHALL have port sk, input, signed 32 x [K][N]: secret key.
REQ-011 The block SHALL have port out_valid, output, 1 bit: message valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts.
REQ-013 The block SHALL have port message, output, N bits: recovered message.

Function
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; u, v, sk SHALL be registered then; later input changes are ignored.
REQ-015 Captured coefficients SHALL be normalized to 0..Q-1 as ((x mod Q)+Q) mod Q, so -8 maps to 9.
REQ-016 The FSM SHALL have states IDLE, MAC, REDUCE, DONE; in_ready=1 only in IDLE.
REQ-017 Transitions SHALL be: IDLE->MAC on accept; MAC->REDUCE after K*N*N cycles; REDUCE->DONE after 1 cycle; DONE->IDLE on out_ready=1.
REQ-018 MAC SHALL perform one product per cycle over counter (k,i,j): acc[(i+j) mod N] += sk[k][i]*u[k][j] if i+j<N, else -=.
REQ-019 Accumulators SHALL be N x signed 16 bit, cleared on accept; the worst case |8*16*16|=2048 fits without overflow.
REQ-020 REDUCE SHALL compute w[i] = ((v[i] - acc[i]) mod Q) normalized to 0..Q-1.
REQ-021 Decode SHALL set bit=1 iff 5 <= w <= 12 (round(2w/Q) mod 2), else 0; message[N-1-i] = bit(w[i]).
REQ-022 out_valid SHALL assert in DONE only; latency SHALL be 34 cycles from the accept edge to out_valid high (K=2, N=4).
REQ-023 message and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Accept SHALL NOT occur in the same cycle as the output handshake; the earliest new accept is the cycle after return to IDLE.
REQ-025 in_valid SHALL be ignored outside IDLE, with no queuing.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counters 0, accumulators 0, out_valid 0, message 0, in_ready 1 after release.
REQ-027 Reset mid-MAC or in DONE SHALL abandon the operation; no out_valid SHALL follow.

Structure
REQ-028 Package baby_kyber_pkg SHALL hold Q, N, K, QHALF=9, coeff_t (signed 32), the FSM state enum and the function mod_q_norm.
REQ-029 One sub-module, kyber_mac_unit, SHALL hold the single multiplier, the negacyclic index/sign logic and the accumulator bank.
REQ-030 The block SHALL contain one multiplier only; no combinational full polynomial product is allowed.

Verification
REQ-031 Zero key: sk=0, u arbitrary, v={9,0,9,0} -> message=4'b1010 at cycle 34.
REQ-032 Negacyclic wrap: sk[0]={0,1,0,0}, u[0]={0,0,0,1}, others 0, v={8,0,0,0} -> w[0]=9, message=4'b1000.
REQ-033 Decode boundaries: sk=0, v={4,5,12,13} -> message=4'b0110; v={-8,0,0,0} -> message=4'b1000.
REQ-034 Backpressure: out_ready low for 10 cycles after out_valid -> message and out_valid stable, in_ready=0, new in_valid ignored.
REQ-035 Reset at MAC cycle 15 -> out_valid stays 0, in_ready=1 after release, next accept decodes correctly.
REQ-036 Round trip: 100 random messages through the encrypt stage with a matching key pair and noise in -1..1 -> every decoded message equals its input.
